// File: rtl/cache_axi_bridge_if.sv
// AXI4 master-port bundle used by cache_axi_bridge.
// Carries the AR/R/AW/W/B channels, with 32-bit address and data and a 4-bit ID.
//   master modport : the bridge side (drives AR/AW/W valids, address and data, and rready/bready)
//   slave modport  : the interconnect/memory side (drives the ready signals and the R/B channels)
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Memory-side responder for one L1 cache. It turns line refills and dirty-line
// writebacks into AXI4 INCR bursts, with one read and one write outstanding.
// A refill of a line that is still being written back is stalled until the
// write response arrives.
//   clk, reset            : clock, synchronous active-high reset
//   i_rd_req / i_rd_addr  : refill request (held until o_rd_rdy), line-aligned address
//   o_rd_rdy              : refill request accepted this cycle
//   o_ret_valid/last/data : refill beats, passed straight through from the R channel
//   i_wr_req / i_wr_addr  : single-cycle writeback pulse and address (offset ignored)
//   i_wr_data             : dirty line, word 0 in bits [31:0]
//   o_wr_rdy              : write buffer free
//   m_axi                 : AXI4 master port
module cache_axi_bridge #(
  parameter int          BYTES_PER_LINE = 16,
  parameter logic [3:0]  AXI_ID         = 4'd0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_rd_req,
  input  logic [31:0]                 i_rd_addr,
  output logic                        o_rd_rdy,
  output logic                        o_ret_valid,
  output logic                        o_ret_last,
  output logic [31:0]                 o_ret_data,
  input  logic                        i_wr_req,
  input  logic [31:0]                 i_wr_addr,
  input  logic [BYTES_PER_LINE*8-1:0] i_wr_data,
  output logic                        o_wr_rdy,
  cache_axi_bridge_if.master          m_axi
);
  localparam int WORDS_PER_LINE = BYTES_PER_LINE / 4;
  localparam int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE);
  localparam int TAG_W          = 32 - OFFSET_WIDTH;
  localparam int CNT_W          = $clog2(WORDS_PER_LINE);
  localparam logic [7:0]       BURST_LEN = 8'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA}         rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

  rstate_t r_rstate, w_rstate_nxt;
  wstate_t r_wstate, w_wstate_nxt;

  logic [31:0]      r_araddr;
  logic [TAG_W-1:0] r_wb_line;
  logic [31:0]      r_wbuf [WORDS_PER_LINE];
  logic [CNT_W-1:0] r_cnt;

  logic w_hazard;
  logic w_rd_rdy, w_rd_accept, w_arvalid, w_rready;
  logic w_wr_rdy, w_wr_accept, w_awvalid, w_wvalid, w_bready;

  // A refill of the line sitting in the write buffer must not overtake the writeback.
  assign w_hazard = (r_wstate != W_IDLE) && (i_rd_addr[31:OFFSET_WIDTH] == r_wb_line);

  // ---------------- read FSM
  always_ff @(posedge clk) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_rdy     = 1'b0;
    w_rd_accept  = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_rd_rdy    = ~w_hazard & ~reset;
        w_rd_accept = i_rd_req & w_rd_rdy;
        if (w_rd_accept) w_rstate_nxt = R_AR;
      end
      R_AR: begin
        w_arvalid = 1'b1;
        if (m_axi.arready) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        w_rready = 1'b1;
        if (m_axi.rvalid && m_axi.rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rd_accept) r_araddr <= i_rd_addr;
  end

  // ---------------- write FSM
  always_ff @(posedge clk) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_rdy     = 1'b0;
    w_wr_accept  = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_wr_rdy    = ~reset;
        w_wr_accept = i_wr_req & ~reset;
        if (w_wr_accept) w_wstate_nxt = W_AW;
      end
      W_AW: begin
        w_awvalid = 1'b1;
        if (m_axi.awready) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_wvalid = 1'b1;
        if (m_axi.wready && (r_cnt == LAST_BEAT)) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_bready = 1'b1;
        if (m_axi.bvalid) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write buffer and beat counter; the counter is re-armed on every AW handshake.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_wb_line <= i_wr_addr[31:OFFSET_WIDTH];
      for (int i = 0; i < WORDS_PER_LINE; i++) r_wbuf[i] <= i_wr_data[i*32 +: 32];
    end
    if (w_awvalid && m_axi.awready)    r_cnt <= '0;
    else if (w_wvalid && m_axi.wready) r_cnt <= r_cnt + 1'b1;
  end

  // ---------------- outputs
  assign o_rd_rdy    = w_rd_rdy;
  assign o_wr_rdy    = w_wr_rdy;
  assign o_ret_valid = w_rready & m_axi.rvalid;
  assign o_ret_last  = w_rready & m_axi.rvalid & m_axi.rlast;
  assign o_ret_data  = m_axi.rdata;

  assign m_axi.arid    = AXI_ID;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arlen   = BURST_LEN;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = w_arvalid;
  assign m_axi.rready  = w_rready;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = {r_wb_line, {OFFSET_WIDTH{1'b0}}};
  assign m_axi.awlen   = BURST_LEN;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = w_awvalid;
  assign m_axi.wdata   = r_wbuf[r_cnt];
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = w_wvalid & (r_cnt == LAST_BEAT);
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.bready  = w_bready;

  // Responses and sub-line address bits carry nothing the bridge acts on.
  logic w_unused_ok;
  assign w_unused_ok = ^{m_axi.rresp, m_axi.bresp,
                         i_rd_addr[OFFSET_WIDTH-1:0], i_wr_addr[OFFSET_WIDTH-1:0]};
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: inputs are driven on the falling edge,
// outputs are checked 1 time unit later.
module tb_cache_axi_bridge;
  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req, wr_req;
  logic [31:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic         rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  int           errs = 0;
  int           checks = 0;

  cache_axi_bridge_if bus ();

  cache_axi_bridge #(.BYTES_PER_LINE(16), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_rdy(rd_rdy),
    .o_ret_valid(ret_valid), .o_ret_last(ret_last), .o_ret_data(ret_data),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_rdy(wr_rdy),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({rd_rdy, wr_rdy, ret_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready} !== 9'b0) begin errs++; $display("FAIL reset_outputs: got %b want 000000000", {rd_rdy, wr_rdy, ret_valid, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast, bus.bready}); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin errs++; $display("FAIL reset_release_rdy: got %b want 11", {rd_rdy, wr_rdy}); end
  endtask

  task automatic test_refill();
    logic [31:0] d [4] = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    @(negedge clk); rd_addr = 32'h1000_0040; rd_req = 1'b1; #1;
    checks++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL refill_accept: rd_rdy got %b want 1", rd_rdy); end
    checks++; if (bus.arvalid !== 1'b0) begin errs++; $display("FAIL refill_ar_early: arvalid got %b want 0", bus.arvalid); end
    @(negedge clk); rd_req = 1'b0; #1;
    checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1000_0040) begin errs++; $display("FAIL refill_ar: arvalid=%b araddr=%h want 1 10000040", bus.arvalid, bus.araddr); end
    checks++; if ({bus.arid, bus.arlen, bus.arsize, bus.arburst} !== {4'd0, 8'd3, 3'b010, 2'b01}) begin errs++; $display("FAIL refill_ar_fields: got %h want %h", {bus.arid, bus.arlen, bus.arsize, bus.arburst}, {4'd0, 8'd3, 3'b010, 2'b01}); end
    bus.arready = 1'b1;
    @(negedge clk); bus.arready = 1'b0; #1;
    checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b1) begin errs++; $display("FAIL refill_rdata_state: arvalid=%b rready=%b want 0 1", bus.arvalid, bus.rready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.rvalid = 1'b1; bus.rdata = d[i]; bus.rlast = (i == 3); #1;
      checks++; if ({ret_valid, ret_last, ret_data} !== {1'b1, 1'(i == 3), d[i]}) begin errs++; $display("FAIL refill_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", i, ret_valid, ret_last, ret_data, i == 3, d[i]); end
    end
    @(negedge clk); bus.rvalid = 1'b0; bus.rlast = 1'b0; #1;
    checks++; if (rd_rdy !== 1'b1 || bus.rready !== 1'b0) begin errs++; $display("FAIL refill_done: rd_rdy=%b rready=%b want 1 0", rd_rdy, bus.rready); end
  endtask

  task automatic test_ar_backpressure();
    logic [31:0] d [4] = '{32'h2222_0000, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003};
    @(negedge clk); rd_addr = 32'h1000_0080; rd_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rd_req = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; #1;
      checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1000_0080 || ret_valid !== 1'b0) begin errs++; $display("FAIL arbp_hold%0d: arvalid=%b araddr=%h ret_valid=%b want 1 10000080 0", k, bus.arvalid, bus.araddr, ret_valid); end
    end
    @(negedge clk); bus.rvalid = 1'b0; bus.arready = 1'b1;
    @(negedge clk); bus.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.rvalid = 1'b1; bus.rdata = d[i]; bus.rlast = (i == 3); #1;
      checks++; if ({ret_valid, ret_last, ret_data} !== {1'b1, 1'(i == 3), d[i]}) begin errs++; $display("FAIL arbp_beat%0d: got v=%b l=%b d=%h want d=%h", i, ret_valid, ret_last, ret_data, d[i]); end
    end
    @(negedge clk); bus.rvalid = 1'b0; bus.rlast = 1'b0; #1;
    checks++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL arbp_done: rd_rdy got %b want 1", rd_rdy); end
  endtask

  task automatic test_writeback();
    logic [31:0] w [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    logic [5:0]  pat = 6'b110101;  // bit k is wready in cycle k: 1,0,1,0,1,1
    int idx = 0;
    @(negedge clk); wr_addr = 32'h2000_0034; wr_data = {w[3], w[2], w[1], w[0]}; wr_req = 1'b1; #1;
    checks++; if (wr_rdy !== 1'b1) begin errs++; $display("FAIL wb_accept: wr_rdy got %b want 1", wr_rdy); end
    @(negedge clk); wr_req = 1'b0; wr_data = '0; #1;
    checks++; if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'h2000_0030 || wr_rdy !== 1'b0) begin errs++; $display("FAIL wb_aw: awvalid=%b awaddr=%h wr_rdy=%b want 1 20000030 0", bus.awvalid, bus.awaddr, wr_rdy); end
    checks++; if ({bus.awid, bus.awlen, bus.awsize, bus.awburst} !== {4'd0, 8'd3, 3'b010, 2'b01}) begin errs++; $display("FAIL wb_aw_fields: got %h want %h", {bus.awid, bus.awlen, bus.awsize, bus.awburst}, {4'd0, 8'd3, 3'b010, 2'b01}); end
    bus.awready = 1'b1;
    @(negedge clk); bus.awready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.wready = pat[k]; #1;
      checks++; if ({bus.wvalid, bus.wlast, bus.wdata, bus.wstrb} !== {1'b1, 1'(idx == 3), w[idx], 4'hF}) begin errs++; $display("FAIL wb_beat_cyc%0d: v=%b l=%b d=%h want v=1 l=%b d=%h", k, bus.wvalid, bus.wlast, bus.wdata, idx == 3, w[idx]); end
      if (pat[k]) idx++;
      @(negedge clk);
    end
    bus.wready = 1'b0; bus.bvalid = 1'b1; #1;
    checks++; if (bus.bready !== 1'b1 || bus.wvalid !== 1'b0 || wr_rdy !== 1'b0) begin errs++; $display("FAIL wb_resp: bready=%b wvalid=%b wr_rdy=%b want 1 0 0", bus.bready, bus.wvalid, wr_rdy); end
    @(negedge clk); bus.bvalid = 1'b0; #1;
    checks++; if (wr_rdy !== 1'b1 || bus.bready !== 1'b0) begin errs++; $display("FAIL wb_done: wr_rdy=%b bready=%b want 1 0", wr_rdy, bus.bready); end
  endtask

  task automatic test_raw_hazard();
    @(negedge clk); wr_addr = 32'h3000_0000; wr_data = {4{32'h3333_CCCC}}; wr_req = 1'b1;
    @(negedge clk); wr_req = 1'b0; rd_addr = 32'h3000_0000; rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_stall_aw%0d: rd_rdy got %b want 0", k, rd_rdy); end
      @(negedge clk);
    end
    rd_addr = 32'h3000_0100; #1;
    checks++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL raw_other_line: rd_rdy got %b want 1", rd_rdy); end
    @(negedge clk); rd_req = 1'b0; rd_addr = 32'h3000_0000; #1;
    checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h3000_0100) begin errs++; $display("FAIL raw_other_ar: arvalid=%b araddr=%h want 1 30000100", bus.arvalid, bus.araddr); end
    bus.arready = 1'b1;
    @(negedge clk); bus.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.rvalid = 1'b1; bus.rdata = 32'h4400_0000 + i; bus.rlast = (i == 3);
    end
    @(negedge clk); bus.rvalid = 1'b0; bus.rlast = 1'b0; rd_req = 1'b1; #1;
    checks++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_stall_after_read: rd_rdy got %b want 0", rd_rdy); end
    bus.awready = 1'b1;
    @(negedge clk); bus.awready = 1'b0; bus.wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (rd_rdy !== 1'b0) begin errs++; $display("FAIL raw_stall_data%0d: rd_rdy got %b want 0", k, rd_rdy); end
      @(negedge clk);
    end
    bus.wready = 1'b0; bus.bvalid = 1'b1; #1;
    checks++; if (rd_rdy !== 1'b0 || bus.bready !== 1'b1) begin errs++; $display("FAIL raw_stall_resp: rd_rdy=%b bready=%b want 0 1", rd_rdy, bus.bready); end
    @(negedge clk); bus.bvalid = 1'b0; #1;
    checks++; if (rd_rdy !== 1'b1) begin errs++; $display("FAIL raw_release: rd_rdy got %b want 1", rd_rdy); end
    @(negedge clk); rd_req = 1'b0; #1;
    checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h3000_0000) begin errs++; $display("FAIL raw_ar: arvalid=%b araddr=%h want 1 30000000", bus.arvalid, bus.araddr); end
    bus.arready = 1'b1;
    @(negedge clk); bus.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.rvalid = 1'b1; bus.rdata = 32'h5500_0000 + i; bus.rlast = (i == 3);
    end
    @(negedge clk); bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  task automatic test_concurrent();
    logic [31:0] w [4] = '{32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002, 32'hC3C3_0003};
    logic [31:0] d [4] = '{32'hD0D0_0000, 32'hD1D1_0001, 32'hD2D2_0002, 32'hD3D3_0003};
    @(negedge clk); rd_addr = 32'h4000_0000; rd_req = 1'b1;
    wr_addr = 32'h5000_0008; wr_data = {w[3], w[2], w[1], w[0]}; wr_req = 1'b1; #1;
    checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin errs++; $display("FAIL conc_accept: got %b want 11", {rd_rdy, wr_rdy}); end
    @(negedge clk); rd_req = 1'b0; wr_req = 1'b0; #1;
    checks++; if ({bus.arvalid, bus.awvalid, bus.araddr, bus.awaddr} !== {2'b11, 32'h4000_0000, 32'h5000_0000}) begin errs++; $display("FAIL conc_addr: arv=%b awv=%b araddr=%h awaddr=%h", bus.arvalid, bus.awvalid, bus.araddr, bus.awaddr); end
    bus.arready = 1'b1; bus.awready = 1'b1;
    @(negedge clk); bus.arready = 1'b0; bus.awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1; bus.rdata = d[i]; bus.rlast = (i == 3); bus.wready = 1'b1; #1;
      checks++; if ({ret_valid, ret_data, bus.wvalid, bus.wlast, bus.wdata} !== {1'b1, d[i], 1'b1, 1'(i == 3), w[i]}) begin errs++; $display("FAIL conc_beat%0d: ret=%h wdata=%h wlast=%b want %h %h %b", i, ret_data, bus.wdata, bus.wlast, d[i], w[i], i == 3); end
      @(negedge clk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
    @(negedge clk); bus.bvalid = 1'b0; #1;
    checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin errs++; $display("FAIL conc_done: got %b want 11", {rd_rdy, wr_rdy}); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); rd_addr = 32'h7000_0000; rd_req = 1'b1;
    wr_addr = 32'h6000_0000; wr_data = {32'h6303_0303, 32'h6202_0202, 32'h6101_0101, 32'h6000_0000}; wr_req = 1'b1;
    @(negedge clk); rd_req = 1'b0; wr_req = 1'b0; bus.awready = 1'b1;
    @(negedge clk); bus.awready = 1'b0; bus.wready = 1'b1;
    repeat (2) @(negedge clk);
    bus.wready = 1'b0; #1;
    checks++; if (bus.wdata !== 32'h6202_0202 || bus.arvalid !== 1'b1) begin errs++; $display("FAIL rstmid_pre: wdata=%h arvalid=%b want 62020202 1", bus.wdata, bus.arvalid); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.rready, ret_valid, rd_rdy, wr_rdy} !== 9'b0) begin errs++; $display("FAIL rstmid_valids: got %b want 000000000", {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.rready, ret_valid, rd_rdy, wr_rdy}); end
    reset = 1'b0; #1;
    checks++; if ({rd_rdy, wr_rdy} !== 2'b11) begin errs++; $display("FAIL rstmid_release: got %b want 11", {rd_rdy, wr_rdy}); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    bus.arready = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    test_reset();
    test_refill();
    test_ar_backpressure();
    test_writeback();
    test_raw_hazard();
    test_concurrent();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Memory-side responder for one cache instance: accepts line-refill reads (rd_req/rd_rdy/ret_*) and dirty-line writebacks (wr_req/wr_rdy/wr_*), and issues them as AXI4 INCR bursts on a master port.
- Sits between each L1 cache and the AXI interconnect.
- One outstanding read and one outstanding write at a time, with read-after-write line hazard protection.

Parameters:
BYTES_PER_LINE, 16, line size in bytes; power of two, >= 8.
WORDS_PER_LINE, BYTES_PER_LINE/4, beats per burst (derived).
OFFSET_WIDTH, $clog2(BYTES_PER_LINE), line offset bits (derived).
AXI_ID, 0, constant value driven on arid/awid.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_req  in  1  cache requests a line refill; held until rd_rdy
rd_addr  in  32  refill address; offset bits are zero
rd_rdy  out  1  read request accepted this cycle when rd_req=1
ret_valid  out  1  refill beat valid; the cache cannot backpressure
ret_last  out  1  final beat of the refill
ret_data  out  32  refill beat data
wr_req  in  1  single-cycle pulse that captures the writeback
wr_addr  in  32  writeback address; offset bits are don't-care
wr_data  in  BYTES_PER_LINE*8  dirty line, word 0 in bits [31:0]
wr_rdy  out  1  write buffer free; the cache may pulse wr_req
arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AXI read address
arvalid out 1, arready in 1  AR handshake
rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1  AXI read data
awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AXI write address
awvalid out 1, awready in 1  AW handshake
wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1  AXI write data
bvalid in 1, bresp in 2, bready out 1  AXI write response

Behaviour:
- Reset values: rd_rdy=0, wr_rdy=0, ret_valid=0, arvalid=0, rready=0, awvalid=0, wvalid=0, wlast=0, bready=0.
- Both FSMs return to IDLE on reset, including mid-burst. Any in-flight AXI transaction is abandoned; the system reset covers this.
- Constant fields: arlen=awlen=WORDS_PER_LINE-1, arsize=awsize=3'b010, arburst=awburst=2'b01, wstrb=4'hF.
- Read FSM states: R_IDLE, R_AR, R_DATA.
  - R_IDLE: rd_rdy = ~rst_hazard, where rst_hazard=1 when the write FSM is not W_IDLE and rd_addr[31:OFFSET_WIDTH] == wb_line.
  - On rd_req & rd_rdy: latch araddr=rd_addr and go to R_AR. arvalid is asserted the following cycle.
  - R_AR: hold arvalid and araddr stable until arready, then go to R_DATA.
  - R_DATA: rready=1. ret_valid=rvalid, ret_data=rdata, ret_last=rlast (combinational pass-through, zero latency).
  - On rvalid & rlast, return to R_IDLE; rd_rdy may be 1 again the next cycle.
  - rresp is ignored.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE: wr_rdy=1. On wr_req, latch the line into a 128-bit (line-wide) buffer and latch wb_line=wr_addr[31:OFFSET_WIDTH].
  - awaddr = {wb_line, OFFSET_WIDTH'b0}; the incoming offset is discarded. Then go to W_AW.
  - wr_req while not in W_IDLE is a protocol error from the cache and is ignored.
  - W_AW: awvalid=1 until awready, then go to W_DATA with beat counter=0.
  - W_DATA: wvalid=1, wdata=buffer word[counter], wlast=(counter==WORDS_PER_LINE-1). Increment the counter on wready.
  - On wready & wlast, go to W_RESP.
  - W_RESP: bready=1. On bvalid, go to W_IDLE. bresp is ignored.
- Reads and writes proceed concurrently. AXI ordering between them is enforced only by the hazard stall.
- Hazard: rd_rdy stays 0 while the read line equals the pending writeback line. It releases the cycle after bvalid is received.
- The counter wraps at WORDS_PER_LINE, but the FSM leaves W_DATA before the wrap is used.

Test Plan:
1. Refill: rd_req with rd_addr=0x1000_0040 → araddr=0x1000_0040 and arlen=3 on the cycle after acceptance. 4 rdata beats D0..D3 appear on ret_data in the same cycles, with ret_last on D3. rd_rdy=1 the cycle after D3.
2. AR backpressure: arready held low for 5 cycles → arvalid and araddr stay stable, and there is no ret_valid before the R beats.
3. Writeback: wr_req with wr_addr=0x2000_0034 and line {W3,W2,W1,W0} → awaddr=0x2000_0030. wdata=W0,W1,W2,W3 with wlast on W3; wready toggles 1,0,1,0,1,1. wr_rdy returns 1 one cycle after bvalid.
4. RAW hazard: writeback of line 0x3000_0000 pending, then rd_req for 0x3000_0000 → rd_rdy=0 until after bvalid, then arvalid. A rd_req for 0x3000_0100 during the same window is accepted immediately.
5. Concurrency: wr_req and rd_req (different lines) in the same cycle → AR and AW both issue, and both complete independently.
6. Reset asserted in W_DATA after 2 beats → all AXI valids 0 the next cycle. wr_rdy=1 and rd_rdy=1 once reset deasserts.
